// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises N_CH requester channels onto a byte-wide memory port,
// splitting each byte/half/word access into consecutive byte cycles.
module mem_port_arbiter #(
    parameter int              N_CH       = 2,
    parameter int              ADDR_W     = 32,
    parameter logic [N_CH-1:0] FLUSH_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     clr,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [2*N_CH-1:0]        size,
    input  logic [ADDR_W*N_CH-1:0]   addr,
    input  logic [32*N_CH-1:0]       wdata,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          done,
    output logic [31:0]              rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state_reg, state_next;
    logic [CH_W-1:0]     ch_reg, last_grant_reg, winner;
    logic [2:0]          n_reg, n_sel, cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, mem_a_int;
    logic [31:0]         wdata_reg, rdata_reg;
    logic [N_CH-1:0]     done_reg, done_next;
    logic [N_CH-1:0]     cand_req;
    logic [7:0]          wbyte;
    logic                accept, found, io_sel, io_block, byte_active;

    logic [1:0]          size_arr  [N_CH];
    logic [ADDR_W-1:0]   addr_arr  [N_CH];
    logic [31:0]         wdata_arr [N_CH];
    logic [CH_W-1:0]     cand_idx  [N_CH];

    // cand_idx[gi] is the channel gi+1 positions after the last grant, wrapping at N_CH.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [3:0] sum;
            assign size_arr[gi]  = size[2*gi +: 2];
            assign addr_arr[gi]  = addr[ADDR_W*gi +: ADDR_W];
            assign wdata_arr[gi] = wdata[32*gi +: 32];
            assign sum           = 4'(last_grant_reg) + 4'(gi + 1);
            assign cand_idx[gi]  = CH_W'((sum >= 4'(N_CH)) ? (sum - 4'(N_CH)) : sum);
            assign cand_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && cand_req[i]) begin
                found  = 1'b1;
                winner = cand_idx[i];
            end
        end
    end

    always_comb begin
        case (size_arr[winner])
            2'd0:    n_sel = 3'd1;
            2'd1:    n_sel = 3'd2;
            default: n_sel = 3'd4;
        endcase
    end

    assign accept = (state_reg == IDLE) && rdy && !clr && (|req);
    assign gnt    = accept ? (N_CH'(1) << winner) : '0;

    // A read spends one extra cycle (cnt_reg == n_reg) collecting the last byte.
    assign byte_active = (state_reg == WRITE) || ((state_reg == READ) && (cnt_reg != n_reg));
    assign mem_a_int   = byte_active ? (addr_reg + ADDR_W'(cnt_reg)) : '0;
    assign mem_a       = mem_a_int;

    generate
        if (ADDR_W >= 18) begin : g_io
            assign io_sel = (mem_a_int[17:16] == 2'b11);
        end else begin : g_no_io
            assign io_sel = 1'b0;
        end
    endgenerate

    assign io_block = (state_reg == WRITE) && io_sel && io_buffer_full;
    assign mem_wr   = (state_reg == WRITE) && rdy && !io_block;

    always_comb begin
        case (cnt_reg[1:0])
            2'd0:    wbyte = wdata_reg[7:0];
            2'd1:    wbyte = wdata_reg[15:8];
            2'd2:    wbyte = wdata_reg[23:16];
            default: wbyte = wdata_reg[31:24];
        endcase
    end

    assign mem_dout = (state_reg == WRITE) ? wbyte : 8'h00;
    assign done     = rdy ? done_reg : '0;
    assign rdata    = rdata_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = we[winner] ? WRITE : READ;
                    cnt_next   = 3'd0;
                end
            end
            READ: begin
                if (clr && FLUSH_MASK[ch_reg]) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else if (cnt_reg == n_reg) begin
                    state_next        = IDLE;
                    cnt_next          = 3'd0;
                    done_next[ch_reg] = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            WRITE: begin
                if (!io_block) begin
                    if (cnt_reg == n_reg - 3'd1) begin
                        state_next        = IDLE;
                        cnt_next          = 3'd0;
                        done_next[ch_reg] = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Everything holds while rdy is low, including a pending done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            n_reg          <= 3'd0;
            ch_reg         <= '0;
            last_grant_reg <= CH_W'(N_CH - 1);
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            done_reg       <= '0;
        end else if (rdy) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            if (accept) begin
                ch_reg         <= winner;
                last_grant_reg <= winner;
                n_reg          <= n_sel;
                addr_reg       <= addr_arr[winner];
                wdata_reg      <= wdata_arr[winner];
            end
            if (accept && !we[winner]) begin
                rdata_reg <= '0;
            end else if (state_reg == READ) begin
                case (cnt_reg)
                    3'd1:    rdata_reg[7:0]   <= mem_din;
                    3'd2:    rdata_reg[15:8]  <= mem_din;
                    3'd3:    rdata_reg[23:16] <= mem_din;
                    3'd4:    rdata_reg[31:24] <= mem_din;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model
// and a 256-byte memory with one cycle of read latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rdy, clr, io_buffer_full;
    logic [1:0]  req, we, gnt, done;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [31:0] rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr;

    logic [7:0]  bus_mem   [256];
    logic [7:0]  model_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr, pl_data;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.N_CH(2), .ADDR_W(32), .FLUSH_MASK(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr), .req(req), .we(we),
        .size(size), .addr(addr), .wdata(wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            bus_mem[pl_addr] <= pl_data;
        end else if (rdy) begin
            mem_din <= bus_mem[mem_a[7:0]];
            if (mem_wr) bus_mem[mem_a[7:0]] <= mem_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        model_mem[a] = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        we[ch]              = w;
        size[2*ch +: 2]     = sz;
        addr[32*ch +: 32]   = a;
        wdata[32*ch +: 32]  = d;
    endtask

    initial begin
        logic [1:0]  exp_done, exp_gnt, done_seen;
        logic [31:0] cur_rdata, a, d;
        logic        active, cur_we, fnd;
        int          cur_ch, last, n, done_cyc, w, mism, ntx;

        rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
        req = '0; we = '0; size = '0; addr = '0; wdata = '0;

        preload(8'h00, 8'h11); preload(8'h01, 8'h22);
        preload(8'h02, 8'h33); preload(8'h03, 8'h44);
        preload(8'h40, 8'hA5); preload(8'h41, 8'h5A);
        preload(8'h20, 8'h01); preload(8'h21, 8'h02);

        // Reset values
        samp();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", 32'(mem_dout), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);

        // Word read on ch0, accepted on the first edge after reset release
        step();
        set_ch(0, 1'b0, 2'd2, 32'h100, 0);
        req = 2'b01;
        rst_n = 1'b1;
        samp();
        chk("rd_gnt", 32'(gnt), 1);
        for (int k = 0; k < 4; k++) begin
            step(); samp();
            chk("rd_mem_a", mem_a, 32'h100 + k);
            chk("rd_mem_wr", 32'(mem_wr), 0);
        end
        step(); samp();
        chk("rd_early_done", 32'(done), 0);
        chk("rd_mem_a_idle", mem_a, 0);
        step(); req = 2'b00; samp();
        chk("rd_done", 32'(done), 1);
        chk("rd_rdata", rdata, 32'h44332211);
        $display("txn directed word read ch0 rdata=%08h", rdata);

        // Both channels requesting continuously after reset: grants alternate
        step();
        rst_n = 1'b0;
        set_ch(0, 1'b1, 2'd0, 32'h10, 32'hAB);
        set_ch(1, 1'b1, 2'd0, 32'h11, 32'hCD);
        req = 2'b11;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            samp();
            exp_gnt = (i % 2 == 1) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10);
            chk("rr_gnt", 32'(gnt), 32'(exp_gnt));
            step();
        end
        req = 2'b00;
        $display("txn directed alternating byte writes ch0/ch1");

        // IO write stalled while the UART buffer is full
        step();
        set_ch(1, 1'b1, 2'd0, 32'h30000, 32'h41);
        req = 2'b10;
        io_buffer_full = 1'b1;
        samp();
        chk("io_gnt", 32'(gnt), 2);
        for (int i = 0; i < 3; i++) begin
            step(); samp();
            chk("io_stall_wr", 32'(mem_wr), 0);
            chk("io_stall_a", mem_a, 32'h30000);
        end
        step(); io_buffer_full = 1'b0; samp();
        chk("io_wr", 32'(mem_wr), 1);
        chk("io_dout", 32'(mem_dout), 32'h41);
        chk("io_early_done", 32'(done), 0);
        step(); req = 2'b00; samp();
        chk("io_done", 32'(done), 2);
        chk("io_wr_after", 32'(mem_wr), 0);
        $display("txn directed io write ch1");

        // clr aborts the flushable ch0 read but not the ch1 read
        step();
        set_ch(0, 1'b0, 2'd1, 32'h20, 0);
        req = 2'b01;
        samp();
        chk("fl_gnt0", 32'(gnt), 1);
        step(); samp();
        chk("fl_a0", mem_a, 32'h20);
        step(); clr = 1'b1; samp();
        chk("fl_a1", mem_a, 32'h21);
        step(); clr = 1'b0;
        set_ch(1, 1'b0, 2'd1, 32'h40, 0);
        req = 2'b10;
        samp();
        chk("fl_no_done0", 32'(done), 0);
        chk("fl_idle_gnt1", 32'(gnt), 2);
        step(); samp();
        chk("fl_c1_done", 32'(done), 0);
        chk("fl_c1_a", mem_a, 32'h40);
        step(); clr = 1'b1; samp();
        chk("fl_c1_a1", mem_a, 32'h41);
        step(); clr = 1'b0; samp();
        chk("fl_c1_early", 32'(done), 0);
        step(); req = 2'b00; samp();
        chk("fl_c1_done", 32'(done), 2);
        chk("fl_c1_rdata", rdata, 32'h00005AA5);
        $display("txn directed flush ch0 aborted, ch1 rdata=%08h", rdata);

        // clr in IDLE suppresses the grant
        step();
        set_ch(0, 1'b1, 2'd0, 32'h50, 32'h77);
        req = 2'b01;
        clr = 1'b1;
        samp();
        chk("clr_idle_gnt", 32'(gnt), 0);
        step(); clr = 1'b0; samp();
        chk("clr_rel_gnt", 32'(gnt), 1);
        step(); step(); req = 2'b00; samp();
        chk("clr_wr_done", 32'(done), 1);

        // rdy low for two cycles during byte 1 of a word write
        step();
        set_ch(1, 1'b1, 2'd2, 32'h80, 32'hDDCCBBAA);
        req = 2'b10;
        samp();
        chk("rdy_gnt", 32'(gnt), 2);
        step(); samp();
        chk("rdy_a0", mem_a, 32'h80);
        chk("rdy_d0", 32'(mem_dout), 32'hAA);
        chk("rdy_w0", 32'(mem_wr), 1);
        for (int i = 0; i < 2; i++) begin
            step(); rdy = 1'b0; samp();
            chk("rdy_frz_wr", 32'(mem_wr), 0);
            chk("rdy_frz_a", mem_a, 32'h81);
        end
        step(); rdy = 1'b1; samp();
        chk("rdy_a1", mem_a, 32'h81);
        chk("rdy_d1", 32'(mem_dout), 32'hBB);
        chk("rdy_w1", 32'(mem_wr), 1);
        step(); samp();
        chk("rdy_a2", mem_a, 32'h82);
        step(); samp();
        chk("rdy_a3", mem_a, 32'h83);
        chk("rdy_early_done", 32'(done), 0);
        step(); req = 2'b00; samp();
        chk("rdy_done", 32'(done), 2);
        chk("rdy_mem", {bus_mem[8'h83], bus_mem[8'h82], bus_mem[8'h81], bus_mem[8'h80]},
            32'hDDCCBBAA);
        $display("txn directed word write ch1 with rdy stall");

        // Reset mid word read
        step();
        set_ch(0, 1'b0, 2'd2, 32'h100, 0);
        req = 2'b01;
        samp();
        chk("mr_gnt", 32'(gnt), 1);
        step(); step(); step();
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        chk("mr_mem_a", mem_a, 0);
        chk("mr_mem_wr", 32'(mem_wr), 0);
        chk("mr_rdata", rdata, 0);
        chk("mr_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        done_seen = 2'b00;
        for (int i = 0; i < 8; i++) begin
            samp();
            done_seen = done_seen | done;
            step();
        end
        chk("mr_no_done", 32'(done_seen), 0);
        $display("txn directed reset mid read");

        // Randomized traffic against the transaction-level model
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        rst_n = 1'b1;
        active = 1'b0; last = 1; cur_ch = 0; cur_we = 1'b0; done_cyc = 0;
        cur_rdata = 0; ntx = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_done = 2'b00;
            if (active && cyc == done_cyc) begin
                exp_done    = 2'b01 << cur_ch;
                req[cur_ch] = 1'b0;
                active      = 1'b0;
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (!req[ch] && cyc < 560 && $urandom_range(0, 2) == 0) begin
                    set_ch(ch, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           $urandom, $urandom);
                    req[ch] = 1'b1;
                end
            end
            samp();
            chk("rnd_done", 32'(done), 32'(exp_done));
            if (exp_done != 2'b00 && !cur_we) chk("rnd_rdata", rdata, cur_rdata);
            exp_gnt = 2'b00;
            if (!active && req != 2'b00) begin
                fnd = 1'b0;
                w = 0;
                for (int off = 1; off <= 2; off++) begin
                    if (!fnd && req[(last + off) % 2]) begin
                        fnd = 1'b1;
                        w = (last + off) % 2;
                    end
                end
                exp_gnt  = 2'b01 << w;
                active   = 1'b1;
                cur_ch   = w;
                cur_we   = we[w];
                n        = (size[2*w +: 2] == 2'd0) ? 1 : ((size[2*w +: 2] == 2'd1) ? 2 : 4);
                done_cyc = cyc + n + (cur_we ? 1 : 2);
                a        = addr[32*w +: 32];
                d        = wdata[32*w +: 32];
                cur_rdata = 0;
                for (int k = 0; k < n; k++) begin
                    if (cur_we) model_mem[8'(a + k)] = d[8*k +: 8];
                    else        cur_rdata[8*k +: 8] = model_mem[8'(a + k)];
                end
                last = w;
                ntx++;
                $display("txn %0d ch=%0d we=%0d n=%0d addr=%08h wdata=%08h exp_rdata=%08h",
                         ntx, w, cur_we, n, a, d, cur_rdata);
            end
            chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
            step();
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (bus_mem[i] !== model_mem[i]) mism++;
        chk("rnd_mem_final", 32'(mism), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
